// File: rtl/busio_seq.sv
// Q-bus style bus-cycle sequencer: runs DATI, DATO and DATIO cycles for the CPU control unit,
// with a RPLY timeout that aborts the cycle and pulses a bus error.
module busio_seq #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned TW      = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          req_dati,
    input  logic          req_dato,
    input  logic          req_rmw,
    input  logic          byte_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [DW-1:0] bad_o,
    input  logic [DW-1:0] bdat_i,
    output logic          bsync,
    output logic          bdin,
    output logic          bdout,
    output logic          bwtbt,
    output logic          bbsy,
    input  logic          breply
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_END  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          rmw_q, rmw_d;
    logic          wr_q, wr_d;
    logic          byte_q, byte_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] bad_q, bad_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          bsync_q, bsync_d;
    logic          bdin_q, bdin_d;
    logic          bdout_q, bdout_d;
    logic          bwtbt_q, bwtbt_d;
    logic          bbsy_q, bbsy_d;

    logic any_req;
    logic dato_win;

    // Priority rmw > dati > dato
    assign any_req  = req_rmw | req_dati | req_dato;
    assign dato_win = req_dato & ~req_rmw & ~req_dati;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rmw_d   = rmw_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        bad_d   = bad_q;
        done_d  = done_q;
        err_d   = err_q;
        bsync_d = bsync_q;
        bdin_d  = bdin_q;
        bdout_d = bdout_q;
        bwtbt_d = bwtbt_q;
        bbsy_d  = bbsy_q;

        if (ce) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_d = S_ADDR;
                        rmw_d   = req_rmw;
                        wr_d    = dato_win;
                        byte_d  = byte_i;
                        wdata_d = wdata_i;
                        bsync_d = 1'b1;
                        bbsy_d  = 1'b1;
                        bad_d   = DW'(addr_i);
                        bwtbt_d = dato_win;
                    end
                end
                S_ADDR: begin
                    cnt_d = TW'(TIMEOUT);
                    if (wr_q) begin
                        state_d = S_WR;
                        bdout_d = 1'b1;
                        bwtbt_d = byte_q;
                        bad_d   = wdata_q;
                    end else begin
                        state_d = S_RD;
                        bdin_d  = 1'b1;
                        bwtbt_d = 1'b0;
                    end
                end
                S_RD, S_WR: begin
                    if (breply) begin
                        if (state_q == S_RD) begin
                            rdata_d = bdat_i;
                            bdin_d  = 1'b0;
                        end else begin
                            bdout_d = 1'b0;
                        end
                        // Read half of an rmw turns straight into the write half, SYNC held
                        if (state_q == S_RD && rmw_q) begin
                            state_d = S_WR;
                            bdout_d = 1'b1;
                            bwtbt_d = byte_q;
                            bad_d   = wdata_i;
                            cnt_d   = TW'(TIMEOUT);
                        end else begin
                            state_d = S_END;
                            bsync_d = 1'b0;
                            bbsy_d  = 1'b0;
                            bwtbt_d = 1'b0;
                        end
                    end else if (cnt_q == TW'(1)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        bsync_d = 1'b0;
                        bdin_d  = 1'b0;
                        bdout_d = 1'b0;
                        bwtbt_d = 1'b0;
                        bbsy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                S_END: begin
                    if (!breply) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rmw_q   <= 1'b0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            bad_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bsync_q <= 1'b0;
            bdin_q  <= 1'b0;
            bdout_q <= 1'b0;
            bwtbt_q <= 1'b0;
            bbsy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rmw_q   <= rmw_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bsync_q <= bsync_d;
            bdin_q  <= bdin_d;
            bdout_q <= bdout_d;
            bwtbt_q <= bwtbt_d;
            bbsy_q  <= bbsy_d;
        end
    end

    assign rdata_o = rdata_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign bad_o   = bad_q;
    assign bsync   = bsync_q;
    assign bdin    = bdin_q;
    assign bdout   = bdout_q;
    assign bwtbt   = bwtbt_q;
    assign bbsy    = bbsy_q;

endmodule

// File: tb/tb_busio_seq.sv
// Directed bench for busio_seq: DATI, DATO, DATIO, RPLY timeout, mid-cycle reset, ce gating.
module tb_busio_seq;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic          req_dati, req_dato, req_rmw, byte_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i, rdata_o, bad_o, bdat_i;
    logic          busy_o, done_o, err_o;
    logic          bsync, bdin, bdout, bwtbt, bbsy, breply;

    int n_cmp = 0;
    int n_bad = 0;
    int sync_cnt, din_cnt, done_cnt, err_cnt;

    busio_seq #(.AW(AW), .DW(DW), .TIMEOUT(4), .TW(6)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .req_dati(req_dati), .req_dato(req_dato), .req_rmw(req_rmw),
        .byte_i(byte_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .bad_o(bad_o), .bdat_i(bdat_i),
        .bsync(bsync), .bdin(bdin), .bdout(bdout), .bwtbt(bwtbt), .bbsy(bbsy),
        .breply(breply)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample just after the edge and tally strobe activity
    task automatic step();
        @(posedge clk);
        #1;
        if (bsync)  sync_cnt++;
        if (bdin)   din_cnt++;
        if (done_o) done_cnt++;
        if (err_o)  err_cnt++;
    endtask

    task automatic clr_tally();
        sync_cnt = 0; din_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset = 1'b1; ce = 1'b1;
        req_dati = 0; req_dato = 0; req_rmw = 0; byte_i = 0;
        addr_i = '0; wdata_i = '0; bdat_i = '0; breply = 0;
        clr_tally();
        repeat (2) @(posedge clk);
        #1;
        check("rst_sync", 32'(bsync), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_bad", 32'(bad_o), 0);
        check("rst_rdata", 32'(rdata_o), 0);
        reset = 1'b0;

        // DATI, reply seen on the third data-phase ce
        addr_i = 16'o100000; req_dati = 1;
        step();
        check("dati_sync", 32'(bsync), 1);
        check("dati_bbsy", 32'(bbsy), 1);
        check("dati_addr", 32'(bad_o), 32'o100000);
        check("dati_wtbt", 32'(bwtbt), 0);
        req_dati = 0;
        step();
        check("dati_din", 32'(bdin), 1);
        step(); step();
        check("dati_din_wait", 32'(bdin), 1);
        breply = 1; bdat_i = 16'o012737;
        step();
        check("dati_din_off", 32'(bdin), 0);
        check("dati_sync_off", 32'(bsync), 0);
        check("dati_rdata", 32'(rdata_o), 32'o012737);
        breply = 0; req_dato = 1;
        step();
        check("dati_done", 32'(done_o), 1);
        check("dati_busy_off", 32'(busy_o), 0);
        req_dato = 0;
        step();
        check("dati_done_clr", 32'(done_o), 0);
        check("dati_no_queue", 32'(busy_o), 0);
        check("dati_sync_cycles", 32'(sync_cnt), 4);
        check("dati_done_cnt", 32'(done_cnt), 1);
        check("dati_err_cnt", 32'(err_cnt), 0);

        // DATO byte, immediate reply
        clr_tally();
        addr_i = 16'o177716; wdata_i = 16'h00FF; byte_i = 1; req_dato = 1;
        step();
        check("dato_addr", 32'(bad_o), 32'o177716);
        check("dato_wtbt_a", 32'(bwtbt), 1);
        req_dato = 0; byte_i = 0; wdata_i = 16'h0000;
        step();
        check("dato_dout", 32'(bdout), 1);
        check("dato_wtbt_d", 32'(bwtbt), 1);
        check("dato_data", 32'(bad_o), 32'h00FF);
        breply = 1;
        step();
        check("dato_dout_off", 32'(bdout), 0);
        check("dato_sync_off", 32'(bsync), 0);
        breply = 0;
        step();
        check("dato_done", 32'(done_o), 1);

        // DATIO: read 0x1234, write 0x5678 under one SYNC
        clr_tally();
        addr_i = 16'o1000; wdata_i = 16'h1111; req_rmw = 1; req_dato = 1;
        step();
        check("rmw_wtbt_a", 32'(bwtbt), 0);
        req_rmw = 0; req_dato = 0;
        step();
        check("rmw_din", 32'(bdin), 1);
        breply = 1; bdat_i = 16'h1234; wdata_i = 16'h5678;
        step();
        check("rmw_turn_sync", 32'(bsync), 1);
        check("rmw_turn_dout", 32'(bdout), 1);
        check("rmw_turn_din", 32'(bdin), 0);
        check("rmw_rdata", 32'(rdata_o), 32'h1234);
        check("rmw_wdata", 32'(bad_o), 32'h5678);
        breply = 0;
        step();
        check("rmw_dout_hold", 32'(bdout), 1);
        breply = 1;
        step();
        check("rmw_dout_off", 32'(bdout), 0);
        breply = 0;
        step();
        check("rmw_done", 32'(done_o), 1);
        step();
        check("rmw_done_cnt", 32'(done_cnt), 1);

        // No reply: DIN held exactly TIMEOUT ce, then error
        clr_tally();
        addr_i = 16'o4000; req_dati = 1;
        step();
        req_dati = 0;
        repeat (4) step();
        check("tmo_din_still", 32'(bdin), 1);
        step();
        check("tmo_err", 32'(err_o), 1);
        check("tmo_sync", 32'(bsync), 0);
        check("tmo_din", 32'(bdin), 0);
        check("tmo_busy", 32'(busy_o), 0);
        check("tmo_rdata", 32'(rdata_o), 32'h1234);
        step();
        check("tmo_err_clr", 32'(err_o), 0);
        check("tmo_din_cycles", 32'(din_cnt), 4);
        check("tmo_done_cnt", 32'(done_cnt), 0);

        // Reset during DIN phase, then a fresh DATO
        clr_tally();
        addr_i = 16'o6000; req_dati = 1;
        step();
        req_dati = 0;
        step();
        check("rst_mid_din_on", 32'(bdin), 1);
        reset = 1'b1;
        #1;
        check("rst_mid_sync", 32'(bsync), 0);
        check("rst_mid_din", 32'(bdin), 0);
        check("rst_mid_busy", 32'(busy_o), 0);
        reset = 1'b0;
        addr_i = 16'o200; wdata_i = 16'hBEEF; req_dato = 1;
        step();
        check("post_addr", 32'(bad_o), 32'o200);
        req_dato = 0;
        step();
        check("post_wtbt", 32'(bwtbt), 0);
        check("post_data", 32'(bad_o), 32'hBEEF);
        breply = 1;
        step();
        breply = 0;
        step();
        check("post_done", 32'(done_o), 1);
        check("post_err_cnt", 32'(err_cnt), 0);

        // dati+dato together with ce toggling
        addr_i = 16'o2000; req_dati = 1; req_dato = 1; ce = 1;
        step();
        check("ce_sync", 32'(bsync), 1);
        check("ce_wtbt", 32'(bwtbt), 0);
        req_dati = 0; req_dato = 0; ce = 0;
        step();
        check("ce_freeze_din", 32'(bdin), 0);
        ce = 1;
        step();
        check("ce_din", 32'(bdin), 1);
        ce = 0; breply = 1; bdat_i = 16'hA5A5;
        step();
        check("ce_freeze_rd", 32'(bdin), 1);
        check("ce_freeze_rdata", 32'(rdata_o), 0);
        ce = 1;
        step();
        check("ce_rdata", 32'(rdata_o), 32'hA5A5);
        check("ce_sync_off", 32'(bsync), 0);
        ce = 0; breply = 0;
        step();
        check("ce_no_done", 32'(done_o), 0);
        ce = 1;
        step();
        check("ce_done", 32'(done_o), 1);
        ce = 0;
        step();
        check("ce_done_hold", 32'(done_o), 1);
        ce = 1;
        step();
        check("ce_done_clr", 32'(done_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
